sha2_stream_core: RTL and testbench

Parametrised SHA-224/SHA-256 compression engine with valid/ready block input and a held digest output. Upstream padding logic delivers pre-padded 512-bit blocks tagged first/last; the core chains them and presents one digest per message. The design is the streaming successor to the fixed single-round SHA-256 core, adding configurable rounds per cycle, SHA-224 mode, back-pressure and multi-message operation.

---
 rtl/sha2_pkg.sv | 117 +++++++++++
 rtl/sha2_round.sv | 28 ++
 rtl/sha2_stream_core.sv | 206 ++++++++++++++++++++
 tb/tb_sha2_stream_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// SHA-2 shared definitions: round constants, initial hash values, bit functions.
// Also holds the control state encoding, the working-variable struct and the
// rounds-per-clock legality check used at elaboration.
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Working variables a..h; a sits in the top word so the packed value
  // lines up with the H0..H7 digest ordering.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic bit rpc_legal(input int rpc);
    return (rpc == 1) || (rpc == 2) || (rpc == 4);
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Message expansion word from W[t-2], W[t-7], W[t-15], W[t-16].
  function automatic logic [31:0] sched_word(input logic [31:0] w2, input logic [31:0] w7,
                                             input logic [31:0] w15, input logic [31:0] w16);
    return small_s1(w2) + w7 + small_s0(w15) + w16;
  endfunction

  function automatic work_t iv_work(input logic m224);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v[255 - 32*i -: 32] = m224 ? IV224[i] : IV256[i];
    end
    return work_t'(v);
  endfunction

  function automatic work_t add_work(input work_t x, input work_t y);
    work_t s;
    s.a = x.a + y.a;
    s.b = x.b + y.b;
    s.c = x.c + y.c;
    s.d = x.d + y.d;
    s.e = x.e + y.e;
    s.f = x.f + y.f;
    s.g = x.g + y.g;
    s.h = x.h + y.h;
    return s;
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One SHA-2 compression round, purely combinational.
// Latency: none; the top chains RPC copies and registers the result.
// Backpressure: not applicable, no handshake at this level.
module sha2_round
  import sha2_pkg::*;
(
  input  work_t       st_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output work_t       st_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = st_i.h + big_s1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
  assign t2 = big_s0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);

  assign st_o.a = t1 + t2;
  assign st_o.b = st_i.a;
  assign st_o.c = st_i.b;
  assign st_o.d = st_i.c;
  assign st_o.e = st_i.d + t1;
  assign st_o.f = st_i.e;
  assign st_o.g = st_i.f;
  assign st_o.h = st_i.g;

endmodule

// File: rtl/sha2_stream_core.sv
// Streaming SHA-224/256 engine: chains pre-padded 512-bit blocks into one digest per message.
// Latency: 64/RPC round cycles + 1 add cycle per block; digest takeable 64/RPC+2 edges after accept.
// Backpressure: blk_ready low while a block is in flight or a digest waits for digest_ready.
module sha2_stream_core
  import sha2_pkg::*;
#(
  parameter int RPC         = 1,
  parameter bit SUPPORT_224 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         mode_224,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy
);

  if (!rpc_legal(RPC)) begin : g_bad_rpc
    $error("sha2_stream_core: RPC must be 1, 2 or 4");
  end

  localparam logic [5:0] LAST_R   = 6'(64 - RPC);
  localparam logic [5:0] RPC_STEP = 6'(RPC);

  // Control state
  state_e       state_q;
  logic [5:0]   r_q;
  logic         blk_ready_q;
  logic         digest_valid_q;
  logic         busy_q;
  logic         msg_open_q;
  logic         last_q;
  logic         mode_q;

  // Datapath state
  work_t        work_q;
  work_t        h_q;
  logic [255:0] digest_q;
  logic [31:0]  w_q [16];

  // Next-state values
  work_t        work_d;
  work_t        h_sum_d;
  logic [31:0]  w_d [16];

  logic         accept;
  logic         fresh;
  logic         mode_sel;
  work_t        iv_sel;

  assign accept   = (state_q == ST_IDLE) && blk_valid && blk_ready_q;
  // A block starts from IV when flagged first, or when nothing is open
  // (which also covers the first block after a reset).
  assign fresh    = blk_first || !msg_open_q;
  assign mode_sel = SUPPORT_224 && mode_224;
  assign iv_sel   = iv_work(mode_sel);
  assign h_sum_d  = add_work(h_q, work_q);

  // Round chain: stage i consumes K[r+i] and W[r+i] (window slot i).
  for (genvar i = 0; i < RPC; i++) begin : g_rnd
    work_t      st_in;
    work_t      st_out;
    logic [5:0] k_idx;

    assign k_idx = r_q + 6'(i);

    if (i == 0) begin : g_head
      assign st_in = work_q;
    end else begin : g_link
      assign st_in = g_rnd[i-1].st_out;
    end

    sha2_round u_round (
      .st_i (st_in),
      .k_i  (K[k_idx]),
      .w_i  (w_q[i]),
      .st_o (st_out)
    );
  end

  assign work_d = g_rnd[RPC-1].st_out;

  // New schedule words W[r+16+j]; for j>=2 the W[t-2] term is itself a
  // word produced this cycle, so those stages feed from earlier ones.
  for (genvar j = 0; j < RPC; j++) begin : g_wn
    logic [31:0] wn;
    if (j < 2) begin : g_from_win
      assign wn = sched_word(w_q[14+j], w_q[9+j], w_q[1+j], w_q[j]);
    end else begin : g_from_new
      assign wn = sched_word(g_wn[j-2].wn, w_q[9+j], w_q[1+j], w_q[j]);
    end
  end

  // Window slides by RPC words; the vacated top slots take the new words.
  for (genvar j = 0; j < 16; j++) begin : g_shift
    if (j + RPC < 16) begin : g_keep
      assign w_d[j] = w_q[j + RPC];
    end else begin : g_fill
      assign w_d[j] = g_wn[j + RPC - 16].wn;
    end
  end

  // Control FSM: block acceptance, round counting, digest hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      r_q            <= '0;
      blk_ready_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      msg_open_q     <= 1'b0;
      last_q         <= 1'b0;
      mode_q         <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_ROUND;
            r_q         <= '0;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            msg_open_q  <= 1'b1;
            last_q      <= blk_last;
            if (fresh) begin
              mode_q <= mode_sel;
            end
          end else begin
            blk_ready_q <= 1'b1;
          end
        end
        ST_ROUND: begin
          r_q <= r_q + RPC_STEP;
          if (r_q == LAST_R) begin
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (last_q) begin
            msg_open_q     <= 1'b0;
            digest_valid_q <= 1'b1;
            state_q        <= ST_OUT;
          end else begin
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (digest_ready) begin
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: schedule window, working variables, chaining value, digest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q   <= '0;
      h_q      <= '0;
      digest_q <= '0;
      for (int j = 0; j < 16; j++) begin
        w_q[j] <= '0;
      end
    end else begin
      if (accept) begin
        for (int j = 0; j < 16; j++) begin
          w_q[j] <= blk_data[511 - 32*j -: 32];
        end
        if (fresh) begin
          h_q    <= iv_sel;
          work_q <= iv_sel;
        end else begin
          work_q <= h_q;
        end
      end else if (state_q == ST_ROUND) begin
        work_q <= work_d;
        w_q    <= w_d;
      end else if (state_q == ST_ADD) begin
        h_q <= h_sum_d;
        if (last_q) begin
          digest_q <= mode_q ? {h_sum_d[255:32], 32'h0} : h_sum_d;
        end
      end
    end
  end

  assign blk_ready    = blk_ready_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sha2_stream_core.sv
// Directed bench for sha2_stream_core: four instances (RPC 1/2/4, and RPC 4
// without SHA-224 support) driven one at a time with known-answer vectors.
module tb_sha2_stream_core;

  localparam int NI = 4;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_ABC224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         blk_valid    [NI];
  logic         blk_ready    [NI];
  logic [511:0] blk_data     [NI];
  logic         blk_first    [NI];
  logic         blk_last     [NI];
  logic         mode_224     [NI];
  logic [255:0] digest       [NI];
  logic         digest_valid [NI];
  logic         digest_ready [NI];
  logic         busy         [NI];

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha2_stream_core #(
      .RPC         (g == 0 ? 1 : (g == 1 ? 2 : 4)),
      .SUPPORT_224 (g != 3)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .blk_valid    (blk_valid[g]),
      .blk_ready    (blk_ready[g]),
      .blk_data     (blk_data[g]),
      .blk_first    (blk_first[g]),
      .blk_last     (blk_last[g]),
      .mode_224     (mode_224[g]),
      .digest       (digest[g]),
      .digest_valid (digest_valid[g]),
      .digest_ready (digest_ready[g]),
      .busy         (busy[g])
    );
  end

  task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one block; t returns the clock edge at which it was accepted.
  task automatic send(input int idx, input logic [511:0] data, input logic first,
                      input logic last, input logic m224, output int t);
    int n;
    @(negedge clk);
    blk_data[idx]  = data;
    blk_first[idx] = first;
    blk_last[idx]  = last;
    mode_224[idx]  = m224;
    blk_valid[idx] = 1'b1;
    n = 0;
    while (blk_ready[idx] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_bit("block accepted", blk_ready[idx], 1'b1);
    t = cyc + 1;
    @(negedge clk);
    blk_valid[idx] = 1'b0;
    blk_first[idx] = 1'b0;
    blk_last[idx]  = 1'b0;
    mode_224[idx]  = 1'b0;
  endtask

  // Wait for digest_valid; t returns the first edge at which it can be taken.
  task automatic wait_digest(input int idx, output int t);
    int n;
    n = 0;
    while (digest_valid[idx] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_bit("digest_valid seen", digest_valid[idx], 1'b1);
    t = cyc + 1;
  endtask

  // Take the digest with a one-cycle digest_ready pulse and check the hand-back.
  task automatic take_digest(input int idx);
    @(negedge clk);
    digest_ready[idx] = 1'b1;
    @(negedge clk);
    digest_ready[idx] = 1'b0;
    check_bit("dv low after take", digest_valid[idx], 1'b0);
    check_bit("ready after take", blk_ready[idx], 1'b1);
    check_bit("idle after take", busy[idx], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    int td;
    int seen;

    for (int i = 0; i < NI; i++) begin
      blk_valid[i]    = 1'b0;
      blk_data[i]     = '0;
      blk_first[i]    = 1'b0;
      blk_last[i]     = 1'b0;
      mode_224[i]     = 1'b0;
      digest_ready[i] = 1'b0;
    end

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_bit("rst blk_ready", blk_ready[i], 1'b0);
      check_bit("rst digest_valid", digest_valid[i], 1'b0);
      check_bit("rst busy", busy[i], 1'b0);
      check_vec("rst digest", digest[i], '0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_bit("ready after release", blk_ready[i], 1'b1);
    end

    // SHA-256 "abc", RPC=1
    send(0, BLK_ABC, 1'b1, 1'b1, 1'b0, t);
    check_bit("busy in flight", busy[0], 1'b1);
    check_bit("ready low in flight", blk_ready[0], 1'b0);
    wait_digest(0, td);
    check_int("abc rpc1 latency", td - t, 66);
    check_vec("abc sha256", digest[0], D_ABC256);
    check_bit("busy digest pending", busy[0], 1'b1);
    check_bit("ready low in OUT", blk_ready[0], 1'b0);
    take_digest(0);

    // SHA-224 "abc", RPC=1
    send(0, BLK_ABC, 1'b1, 1'b1, 1'b1, t);
    wait_digest(0, td);
    check_vec("abc sha224", digest[0], D_ABC224);
    take_digest(0);

    // Two-block message, RPC=2; mode_224 on the second block must be ignored
    send(1, BLK_TWO1, 1'b1, 1'b0, 1'b0, t);
    send(1, BLK_TWO2, 1'b0, 1'b1, 1'b1, t2);
    check_int("block period rpc2", t2 - t, 34);
    check_bit("no digest mid message", digest_valid[1], 1'b0);
    wait_digest(1, td);
    check_int("two-block rpc2 latency", td - t2, 34);
    check_vec("two-block sha256", digest[1], D_TWO);
    take_digest(1);

    // Empty message, RPC=4, digest held while digest_ready stays low
    send(2, BLK_EMPTY, 1'b1, 1'b1, 1'b0, t);
    wait_digest(2, td);
    check_int("empty rpc4 latency", td - t, 18);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_vec("empty digest held", digest[2], D_EMPTY);
      check_bit("empty dv held", digest_valid[2], 1'b1);
      check_bit("empty ready low", blk_ready[2], 1'b0);
    end
    take_digest(2);

    // SHA-224 not supported: mode_224 ignored, SHA-256 result
    send(3, BLK_ABC, 1'b1, 1'b1, 1'b1, t);
    wait_digest(3, td);
    check_vec("no-224 forces sha256", digest[3], D_ABC256);
    take_digest(3);

    // Reset at round 30 of the first block; next block without blk_first restarts from IV
    send(0, BLK_TWO1, 1'b1, 1'b0, 1'b0, t);
    while (cyc < t + 30) @(negedge clk);
    check_bit("busy before mid reset", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    check_bit("mid rst busy", busy[0], 1'b0);
    check_bit("mid rst blk_ready", blk_ready[0], 1'b0);
    check_bit("mid rst digest_valid", digest_valid[0], 1'b0);
    check_vec("mid rst digest", digest[0], '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_bit("ready after mid rst", blk_ready[0], 1'b1);
    send(0, BLK_ABC, 1'b0, 1'b1, 1'b0, t);
    wait_digest(0, td);
    check_int("abc after rst latency", td - t, 66);
    check_vec("abc after rst", digest[0], D_ABC256);
    take_digest(0);

    // blk_first while a message is open: old message dropped, single digest
    send(1, BLK_TWO1, 1'b1, 1'b0, 1'b0, t);
    send(1, BLK_ABC, 1'b1, 1'b1, 1'b0, t2);
    check_bit("abandoned gives no digest", digest_valid[1], 1'b0);
    wait_digest(1, td);
    check_int("restart rpc2 latency", td - t2, 34);
    check_vec("restart abc", digest[1], D_ABC256);
    take_digest(1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (digest_valid[1] === 1'b1) seen++;
    end
    check_int("only one digest", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
